// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: packs an MSB-first byte stream into
// 32-bit words and writes them to consecutive word addresses while holding the CPU.
module instruction_loader #(
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ASM_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [1:0]            r_byte_idx;
  logic [1:0]            w_byte_idx_next;
  logic [CNT_W-1:0]      r_word_idx;
  logic [CNT_W-1:0]      w_word_idx_next;
  logic [CNT_W-1:0]      w_word_idx_inc;
  logic [CNT_W-1:0]      r_num_words;
  logic [CNT_W-1:0]      w_num_words_next;
  // Only the first three bytes need storage; the fourth is merged on the fly.
  logic [ASM_W-1:0]      r_asm;
  logic [ASM_W-1:0]      w_asm_next;

  logic                  r_byte_ready;
  logic                  r_we;
  logic                  w_we_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     w_data_next;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_error;

  logic                  w_xfer;
  logic                  w_len_illegal;

  assign w_xfer         = r_byte_ready && byte_valid;
  assign w_len_illegal  = (num_words == '0) || (num_words > CNT_W'(DEPTH));
  assign w_word_idx_inc = r_word_idx + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    w_state_next     = r_state;
    w_byte_idx_next  = r_byte_idx;
    w_word_idx_next  = r_word_idx;
    w_num_words_next = r_num_words;
    w_asm_next       = r_asm;
    w_we_next        = 1'b0;
    w_addr_next      = r_addr;
    w_data_next      = r_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_num_words_next = num_words;
          w_byte_idx_next  = 2'd0;
          w_word_idx_next  = '0;
          w_state_next     = w_len_illegal ? S_ERROR : S_RECV;
        end
      end
      S_RECV: begin
        if (w_xfer) begin
          w_asm_next = {r_asm[ASM_W-9:0], byte_data};
          if (r_byte_idx == 2'd3) begin
            w_state_next    = S_WRITE;
            w_byte_idx_next = 2'd0;
            w_we_next       = 1'b1;
            w_addr_next     = ADDR_WIDTH'({r_word_idx, 2'b00});
            w_data_next     = {r_asm, byte_data};
          end else begin
            w_byte_idx_next = r_byte_idx + 2'd1;
          end
        end
      end
      S_WRITE: begin
        w_word_idx_next = w_word_idx_inc;
        w_state_next    = (w_word_idx_inc == r_num_words) ? S_DONE : S_RECV;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_idx   <= 2'd0;
      r_word_idx   <= '0;
      r_num_words  <= '0;
      r_asm        <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_byte_idx   <= w_byte_idx_next;
      r_word_idx   <= w_word_idx_next;
      r_num_words  <= w_num_words_next;
      r_asm        <= w_asm_next;
      r_byte_ready <= (w_state_next == S_RECV);
      r_we         <= w_we_next;
      r_addr       <= w_addr_next;
      r_data       <= w_data_next;
      r_cpu_hold   <= (w_state_next == S_RECV) || (w_state_next == S_WRITE);
      r_done       <= (w_state_next == S_DONE);
      r_error      <= (w_state_next == S_ERROR);
    end
  end

  assign byte_ready        = r_byte_ready;
  assign mem_write_enable  = r_we;
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_data;
  assign cpu_hold          = r_cpu_hold;
  assign done              = r_done;
  assign error             = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: drivers queue expected writes,
// a negedge monitor pops and compares every mem_write_enable strobe.
module tb_instruction_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic        prev_we = 1'b0;
  logic [63:0] exp_q[$];

  instruction_loader #(.DEPTH(10), .ADDR_WIDTH(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .num_words         (num_words),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .cpu_hold          (cpu_hold),
    .done              (done),
    .error             (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (mem_write_enable === 1'b1) begin
      n_writes++;
      chk("we_one_cycle", 128'(prev_we), 128'(1'b0));
      chk("we_byte_ready_low", 128'(byte_ready), 128'(1'b0));
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 128'(mem_write_address), 128'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 128'(mem_write_address), 128'(e[63:32]));
        chk("write_data", 128'(mem_write_data), 128'(e[31:0]));
      end
    end
    prev_we = mem_write_enable;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] all_outs();
    return {byte_ready, mem_write_enable, mem_write_address, mem_write_data,
            cpu_hold, done, error};
  endfunction

  // Called at a negedge; returns at the negedge after the byte transferred
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (byte_ready !== 1'b1) chk("byte_ready_timeout", 128'(byte_ready), 128'(1'b1));
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Strobe must appear in the cycle right after the 4th byte
  task automatic check_write_cycle();
    chk("we_latency", 128'(mem_write_enable), 128'(1'b1));
    chk("done_low_in_write", 128'(done), 128'(1'b0));
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gap);
    logic [31:0] wv;
    wv = w;
    exp_q.push_back({addr, w});
    for (int i = 3; i >= 0; i--) begin
      send_byte(wv[i*8 +: 8]);
      if (i != 0) gap_cycles(gap);
    end
    check_write_cycle();
    gap_cycles(gap);
  endtask

  task automatic do_start(input logic [31:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clock);
    start     = 1'b0;
  endtask

  task automatic two_word_load(input int gap);
    do_start(32'd2);
    chk("cpu_hold_rise", 128'(cpu_hold), 128'(1'b1));
    chk("ready_after_start", 128'(byte_ready), 128'(1'b1));
    send_word(32'h2008_0005, 32'h0, gap);
    send_word(32'h0000_0008, 32'h4, gap);
    if (gap == 0) @(negedge clock);
    chk("done_2w", 128'(done), 128'(1'b1));
    chk("hold_2w", 128'(cpu_hold), 128'(1'b0));
    chk("ready_2w", 128'(byte_ready), 128'(1'b0));
  endtask

  int wbase;

  initial begin
    reset      = 1'b1;
    start      = 1'b1;
    byte_valid = 1'b1;
    num_words  = 32'd2;
    byte_data  = 8'hAA;
    repeat (2) begin
      @(negedge clock);
      chk("reset_outputs", 128'(all_outs()), 128'(0));
    end
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clock);
    chk("idle_outputs", 128'(all_outs()), 128'(0));

    two_word_load(0);
    two_word_load(3);

    // Illegal lengths
    wbase = n_writes;
    do_start(32'd0);
    chk("err_zero", 128'(error), 128'(1'b1));
    chk("hold_zero", 128'(cpu_hold), 128'(1'b0));
    chk("done_cleared", 128'(done), 128'(1'b0));
    do_start(32'd11);
    chk("err_eleven", 128'(error), 128'(1'b1));
    chk("hold_eleven", 128'(cpu_hold), 128'(1'b0));
    gap_cycles(3);
    chk("err_held", 128'(error), 128'(1'b1));
    chk("err_no_writes", 128'(n_writes - wbase), 128'(0));
    do_start(32'd1);
    chk("err_cleared", 128'(error), 128'(1'b0));
    chk("hold_after_err", 128'(cpu_hold), 128'(1'b1));
    send_word(32'hDEAD_BEEF, 32'h0, 0);
    @(negedge clock);
    chk("done_1w", 128'(done), 128'(1'b1));

    // Full depth
    wbase = n_writes;
    do_start(32'd10);
    for (int k = 0; k < 10; k++) begin
      send_word(32'(k), 32'(k * 4), 0);
      if (k < 9) chk("hold_mid_full", 128'(cpu_hold), 128'(1'b1));
    end
    @(negedge clock);
    chk("done_full", 128'(done), 128'(1'b1));
    chk("full_write_count", 128'(n_writes - wbase), 128'(10));

    // Abort after 6th byte of a 3-word load
    wbase = n_writes;
    do_start(32'd3);
    send_word(32'h1122_3344, 32'h0, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_outputs", 128'(all_outs()), 128'(0));
    reset = 1'b0;
    gap_cycles(2);
    chk("abort_write_count", 128'(n_writes - wbase), 128'(1));
    chk("abort_idle", 128'(all_outs()), 128'(0));

    do_start(32'd1);
    send_word(32'hCAFE_F00D, 32'h0, 0);
    @(negedge clock);
    chk("restart_done", 128'(done), 128'(1'b1));

    // Start mid-RECV must be ignored
    wbase = n_writes;
    do_start(32'd2);
    exp_q.push_back({32'h0, 32'hA1B2_C3D4});
    send_byte(8'hA1);
    send_byte(8'hB2);
    do_start(32'd5);
    chk("ready_after_ignored_start", 128'(byte_ready), 128'(1'b1));
    send_byte(8'hC3);
    send_byte(8'hD4);
    check_write_cycle();
    send_word(32'h0BAD_CAFE, 32'h4, 0);
    @(negedge clock);
    chk("ignored_start_done", 128'(done), 128'(1'b1));
    chk("ignored_start_writes", 128'(n_writes - wbase), 128'(2));

    gap_cycles(3);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
